multicycle_control_unit: RTL and testbench

//   Multi-cycle RISC-V main control FSM; successor to the single-cycle opcode decoder.

---
 rtl/multicycle_control_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// bounded mem_ready wait, retired-instruction counter.
// Ports: clk, rst (sync, active high); op_code/zero/mem_ready in;
//   datapath strobes, alu selects, instr_done, bus_error, illegal_instr,
//   retire_cnt out.
// Build option: define ILLEGAL_TRAP_EN to trap on unknown opcodes
//   (otherwise they retire as NOPs).
module multicycle_control_unit #(
  parameter int OPCODE_W       = 7,
  parameter int ALU_OP_W       = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RETIRE_CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_W-1:0]     op_code,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    ir_write,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    mem_to_reg,
  output logic                    reg_write,
  output logic [1:0]              alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [ALU_OP_W-1:0]     alu_op,
  output logic                    pc_src,
  output logic                    instr_done,
  output logic                    bus_error,
  output logic                    illegal_instr,
  output logic [RETIRE_CNT_W-1:0] retire_cnt
);

  localparam int WAIT_W =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_R     = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I     = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(7'b1100011);

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(2'b00);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(2'b01);
  localparam logic [ALU_OP_W-1:0] ALU_RF  = ALU_OP_W'(2'b10);
  localparam logic [ALU_OP_W-1:0] ALU_IF  = ALU_OP_W'(2'b11);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  state_e                  state_q, state_d;
  logic [OPCODE_W-1:0]     op_q, op_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [RETIRE_CNT_W-1:0] cnt_q, cnt_d;

  logic is_ld, is_st, is_r, is_i, is_beq;
  logic dec_known;
  logic waiting, expired;

  assign is_ld  = (op_q == OP_LOAD);
  assign is_st  = (op_q == OP_STORE);
  assign is_r   = (op_q == OP_R);
  assign is_i   = (op_q == OP_I);
  assign is_beq = (op_q == OP_BEQ);

  assign dec_known = (op_code == OP_LOAD) || (op_code == OP_STORE) ||
                     (op_code == OP_R)    || (op_code == OP_I)     ||
                     (op_code == OP_BEQ);

  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) &&
                   !mem_ready;

  // Fires on the last allowed stalled cycle; a late mem_ready still wins.
  assign expired = (TIMEOUT_CYCLES != 0) && waiting &&
                   (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    pc_src        = 1'b0;
    instr_done    = 1'b0;
    bus_error     = 1'b0;
    illegal_instr = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (expired) begin
          bus_error = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        op_d      = op_code;
        if (dec_known) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          instr_done = 1'b1;
          state_d    = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        alu_src_a = 2'b01;
        unique case (1'b1)
          is_ld, is_st: begin
            alu_src_b = 2'b10;
            state_d   = S_MEM;
          end
          is_r: begin
            alu_op  = ALU_RF;
            state_d = S_WB;
          end
          is_i: begin
            alu_src_b = 2'b10;
            alu_op    = ALU_IF;
            state_d   = S_WB;
          end
          is_beq: begin
            alu_op     = ALU_SUB;
            pc_src     = 1'b1;
            pc_write   = zero;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = is_ld;
        mem_write = is_st;
        if (mem_ready) begin
          if (is_ld) begin
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end else if (expired) begin
          bus_error = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        illegal_instr = 1'b1;
`endif
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
    // Outputs are forced quiet during reset so an abandoned
    // instruction cannot write anything on the reset cycle.
    if (rst) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = ALU_ADD;
      pc_src        = 1'b0;
      instr_done    = 1'b0;
      bus_error     = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  always_comb begin
    wait_d = '0;
    if (waiting && !expired && (TIMEOUT_CYCLES != 0)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q + {{(RETIRE_CNT_W-1){1'b0}}, instr_done};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: vector table,
// hand-written corner sequences, randomized run against a reference model.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  localparam int TO = 16;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  op_code = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, reg_write, pc_src, instr_done;
  logic        bus_error, illegal_instr;
  logic [1:0]  alu_src_a, alu_src_b, alu_op;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  multicycle_control_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .instr_done(instr_done), .bus_error(bus_error),
    .illegal_instr(illegal_instr), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  logic [16:0] act;
  assign act = {pc_write, ir_write, i_or_d, mem_read, mem_write,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_src, instr_done, bus_error, illegal_instr};

  function automatic logic [16:0] pk(
    input int pcw, input int irw, input int iod, input int rd,
    input int wr, input int m2r, input int rw, input int a,
    input int b, input int ao, input int ps, input int dn,
    input int be, input int il);
    logic [16:0] v;
    v = {pcw[0], irw[0], iod[0], rd[0], wr[0], m2r[0], rw[0],
         a[1:0], b[1:0], ao[1:0], ps[0], dn[0], be[0], il[0]};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [6:0] op,
                       input logic z, input logic mr);
    rst       = r;
    op_code   = op;
    zero      = z;
    mem_ready = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 7'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 7'd0, 1'b0, 1'b0);
    tick();
  endtask

  // Reference model: instruction step, latched opcode, stall count, retires.
  int          m_ph = PF;
  logic [6:0]  m_op = '0;
  int          m_wait = 0;
  logic [31:0] m_cnt = '0;

  function automatic bit known(input logic [6:0] op);
    return op inside {LD, ST, RT, IT, BQ};
  endfunction

  task automatic model_step(input logic r, input logic [6:0] op,
                            input logic z, input logic mr,
                            output logic [16:0] e);
    int nph;
    int pcw, irw, iod, rd, wr, m2r, rw, a, b, ao, ps, dn, be, il;
    bit stall;
    nph = m_ph; stall = 1'b0;
    pcw = 0; irw = 0; iod = 0; rd = 0; wr = 0; m2r = 0; rw = 0;
    a = 0; b = 0; ao = 0; ps = 0; dn = 0; be = 0; il = 0;
    if (r) begin
      m_ph = PF; m_op = '0; m_wait = 0; m_cnt = '0;
      e = '0;
      return;
    end
    case (m_ph)
      PF: begin
        rd = 1; b = 1;
        if (mr) begin pcw = 1; irw = 1; nph = PD; end
        else stall = 1'b1;
      end
      PD: begin
        b = 2; m_op = op;
        if (known(op)) nph = PE;
        else if (TRAP) nph = PT;
        else begin dn = 1; nph = PF; end
      end
      PE: begin
        a = 1;
        if (m_op == LD || m_op == ST) begin b = 2; nph = PM; end
        else if (m_op == RT) begin ao = 2; nph = PW; end
        else if (m_op == IT) begin b = 2; ao = 3; nph = PW; end
        else begin ao = 1; ps = 1; pcw = int'(z); dn = 1; nph = PF; end
      end
      PM: begin
        iod = 1;
        rd = int'(m_op == LD);
        wr = int'(m_op == ST);
        if (mr) begin
          if (m_op == LD) nph = PW;
          else begin dn = 1; nph = PF; end
        end else stall = 1'b1;
      end
      PW: begin
        rw = 1; m2r = int'(m_op == LD); dn = 1; nph = PF;
      end
      default: il = 1;
    endcase
    if (stall) begin
      m_wait++;
      if (TO > 0 && m_wait == TO) begin be = 1; nph = PF; end
    end
    if (nph != m_ph || be != 0) m_wait = 0;
    e = pk(pcw, irw, iod, rd, wr, m2r, rw, a, b, ao, ps, dn, be, il);
    if (dn != 0) m_cnt = m_cnt + 32'd1;
    m_ph = nph;
  endtask

  typedef struct {
    logic        r;
    logic [6:0]  op;
    logic        z;
    logic        mr;
    logic [16:0] ev;
    logic [31:0] ec;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [6:0] op, input logic z,
                     input logic mr, input logic [16:0] ev,
                     input logic [31:0] ec);
    vec_t v;
    v.r = r; v.op = op; v.z = z; v.mr = mr; v.ev = ev; v.ec = ec;
    tv.push_back(v);
  endtask

  logic [16:0] FV1, FV0, DV, ER, EI, WR, EB1, EB0;

  initial begin
    int nrd, done_at, be_at, pw;
    logic m2r, be;

    FV1 = pk(1,1,0,1,0,0,0, 0,1,0, 0,0,0,0);
    FV0 = pk(0,0,0,1,0,0,0, 0,1,0, 0,0,0,0);
    DV  = pk(0,0,0,0,0,0,0, 0,2,0, 0,0,0,0);
    ER  = pk(0,0,0,0,0,0,0, 1,0,2, 0,0,0,0);
    EI  = pk(0,0,0,0,0,0,0, 1,2,3, 0,0,0,0);
    WR  = pk(0,0,0,0,0,0,1, 0,0,0, 0,1,0,0);
    EB1 = pk(1,0,0,0,0,0,0, 1,0,1, 1,1,0,0);
    EB0 = pk(0,0,0,0,0,0,0, 1,0,1, 1,1,0,0);

    add(1'b0, RT, 1'b0, 1'b1, FV1, 32'd0);
    add(1'b0, RT, 1'b0, 1'b1, DV,  32'd0);
    add(1'b0, RT, 1'b0, 1'b1, ER,  32'd0);
    add(1'b0, RT, 1'b0, 1'b1, WR,  32'd0);
    add(1'b0, BQ, 1'b1, 1'b1, FV1, 32'd1);
    add(1'b0, BQ, 1'b1, 1'b1, DV,  32'd1);
    add(1'b0, BQ, 1'b1, 1'b1, EB1, 32'd1);
    add(1'b0, BQ, 1'b0, 1'b1, FV1, 32'd2);
    add(1'b0, BQ, 1'b0, 1'b1, DV,  32'd2);
    add(1'b0, BQ, 1'b0, 1'b1, EB0, 32'd2);
    add(1'b0, IT, 1'b0, 1'b0, FV0, 32'd3);
    add(1'b0, IT, 1'b0, 1'b1, FV1, 32'd3);
    add(1'b0, IT, 1'b0, 1'b0, DV,  32'd3);
    add(1'b0, IT, 1'b1, 1'b0, EI,  32'd3);
    add(1'b0, IT, 1'b0, 1'b0, WR,  32'd3);
    add(1'b0, IT, 1'b0, 1'b0, FV0, 32'd4);
    add(1'b1, IT, 1'b0, 1'b1, 17'd0, 32'd4);
    add(1'b0, RT, 1'b0, 1'b1, FV1, 32'd0);

    // Reset state
    drive(1'b1, 7'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, RT, 1'b1, 1'b1);
    chk("rst_out", 32'(act), 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    tick();

    foreach (tv[k]) begin
      drive(tv[k].r, tv[k].op, tv[k].z, tv[k].mr);
      chk($sformatf("vec%0d_out", k), 32'(act), 32'(tv[k].ev));
      chk($sformatf("vec%0d_cnt", k), retire_cnt, tv[k].ec);
      tick();
    end

    // LOAD with mem_ready late by 3 cycles in MEM
    do_reset();
    nrd = 0; done_at = -1; m2r = 1'b0;
    for (int i = 0; i < 20 && done_at < 0; i++) begin
      drive(1'b0, LD, 1'b0, (i == 0 || i >= 6));
      if (mem_read && i_or_d) nrd++;
      if (instr_done) begin done_at = i; m2r = mem_to_reg; end
      tick();
    end
    chk("ld_mem_read_cycles", nrd, 4);
    chk("ld_total_cycles", done_at + 1, 8);
    chk("ld_mem_to_reg", 32'(m2r), 32'd1);
    drive(1'b0, LD, 1'b0, 1'b0);
    chk("ld_cnt", retire_cnt, 32'd1);
    tick();

    // FETCH timeout
    do_reset();
    be_at = -1; pw = 0;
    for (int i = 0; i < 40 && be_at < 0; i++) begin
      drive(1'b0, RT, 1'b0, 1'b0);
      if (pc_write || ir_write) pw++;
      if (bus_error) be_at = i;
      tick();
    end
    chk("to_cycle", be_at + 1, TO);
    chk("to_nowrite", pw, 0);
    drive(1'b0, RT, 1'b0, 1'b0);
    chk("to_refetch", 32'({mem_read, i_or_d, bus_error}), 32'(3'b100));
    chk("to_cnt", retire_cnt, 32'd0);
    tick();

    // mem_ready on the final allowed cycle wins
    do_reset();
    be = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      drive(1'b0, RT, 1'b0, 1'b0);
      be = be | bus_error;
      tick();
    end
    drive(1'b0, RT, 1'b0, 1'b1);
    chk("to_edge_ready", 32'({be, bus_error, ir_write, pc_write}),
        32'(4'b0011));
    tick();
    drive(1'b0, RT, 1'b0, 1'b0);
    chk("to_edge_decode", 32'(alu_src_b), 32'(2'b10));
    tick();

    // Unknown opcode
    do_reset();
    drive(1'b0, BAD, 1'b0, 1'b1);
    tick();
    drive(1'b0, BAD, 1'b0, 1'b1);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_decode", 32'({instr_done, illegal_instr}), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, BAD, 1'b0, 1'($urandom_range(0, 1)));
      chk("ill_trap", 32'(act), 32'(pk(0,0,0,0,0,0,0,0,0,0,0,0,0,1)));
      tick();
    end
    drive(1'b1, RT, 1'b0, 1'b1);
    chk("ill_rst", 32'(illegal_instr), 32'd0);
    tick();
    drive(1'b0, RT, 1'b0, 1'b1);
    chk("ill_refetch", 32'(act), 32'(FV1));
    tick();
`else
    chk("nop_decode", 32'(act), 32'(pk(0,0,0,0,0,0,0,0,2,0,0,1,0,0)));
    tick();
    drive(1'b0, RT, 1'b0, 1'b0);
    chk("nop_refetch", 32'(act), 32'(FV0));
    chk("nop_cnt", retire_cnt, 32'd1);
    tick();
`endif

    // Reset during STORE memory phase
    do_reset();
    drive(1'b0, ST, 1'b0, 1'b1);
    tick();
    drive(1'b0, ST, 1'b0, 1'b0);
    tick();
    drive(1'b0, ST, 1'b0, 1'b0);
    tick();
    drive(1'b0, ST, 1'b0, 1'b0);
    chk("st_mem", 32'({i_or_d, mem_write, mem_read}), 32'(3'b110));
    tick();
    drive(1'b1, ST, 1'b0, 1'b1);
    chk("st_rst_out", 32'(act), 32'd0);
    tick();
    drive(1'b0, ST, 1'b0, 1'b0);
    chk("st_restart", 32'(act), 32'(FV0));
    chk("st_cnt", retire_cnt, 32'd0);
    tick();

    // Randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic        r, z, m;
      logic [6:0]  o;
      logic [16:0] e;
      logic [31:0] ec;
      int          th, sel;
      th  = ((i / 500) % 3 == 0) ? 70 : (((i / 500) % 3 == 1) ? 30 : 4);
      r   = (i < 2) || ($urandom_range(0, 99) == 0);
      sel = int'($urandom_range(0, 15));
      if (sel < 3) o = LD;
      else if (sel < 6) o = ST;
      else if (sel < 9) o = RT;
      else if (sel < 12) o = IT;
      else if (sel < 15) o = BQ;
      else o = 7'($urandom_range(0, 127));
      z = 1'($urandom_range(0, 1));
      m = ($urandom_range(0, 99) < th);
      drive(r, o, z, m);
      ec = m_cnt;
      model_step(r, o, z, m, e);
      chk("rand_out", 32'(act), 32'(e));
      chk("rand_cnt", retire_cnt, ec);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
